gyro_rate_est: RTL

- Recovers angular rate (deg/s) per axis from a stream of 16-bit tilt angles: the inverse of the tilt integrator.
- Samples X/Y/Z tilt on a fixed divided tick, differentiates against the previous sample, averages over a sliding window, then scales, saturates and deadbands.
- Sits downstream of the tilt integrator for closed-loop self-check, and feeds the display/debug path with filtered rates.

---
 rtl/gyro_rate_est.sv | 128 ++++++++++++
 1 files changed

// File: rtl/gyro_rate_est.sv
// gyro_rate_est: recovers per-axis angular rate from tilt samples via difference, windowed average, scale and saturate.
// Define DEADBAND_EN to zero output rates strictly between DB_LO and DB_HI.
module gyro_rate_est #(
    parameter int SAMPLE_DIV = 50000,
    parameter int AVG_LOG2   = 3,
    parameter int RATE_SCALE = 1000,
    parameter int DB_LO      = -42,
    parameter int DB_HI      = 10
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic signed [15:0] X,
    input  logic signed [15:0] Y,
    input  logic signed [15:0] Z,
    output logic signed [15:0] RX,
    output logic signed [15:0] RY,
    output logic signed [15:0] RZ,
    output logic               VALID,
    output logic               OVF
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 17 + AVG_LOG2;
    localparam int PW    = 28;
    localparam logic [15:0] LAST = 16'(SAMPLE_DIV - 1);

    typedef enum logic [2:0] {PRIME, IDLE, DIFF, ACCUM, SCALE, OUT} state_t;

    state_t                st, nxt;
    logic [15:0]           cnt;
    logic                  tick;
    logic [AVG_LOG2-1:0]   wptr;
    logic signed [15:0]    smp   [3];
    logic signed [15:0]    cur   [3];
    logic signed [15:0]    prev  [3];
    logic signed [16:0]    delta [3];
    logic signed [SW-1:0]  sum   [3];
    logic signed [16:0]    win   [3][DEPTH];
    logic signed [16:0]    avg   [3];
    logic signed [PW-1:0]  prod  [3];
    logic signed [15:0]    sat   [3];
    logic signed [15:0]    sat_q [3];
    logic signed [15:0]    db    [3];
    logic signed [15:0]    rate  [3];
    logic [2:0]            clip;

    always_comb begin
        smp[0] = X;
        smp[1] = Y;
        smp[2] = Z;
        tick   = EN && cnt == LAST;
        for (int a = 0; a < 3; a++) begin
            avg[a]  = 17'(sum[a] >>> AVG_LOG2);
            prod[a] = PW'(avg[a]) * PW'(RATE_SCALE);
            clip[a] = prod[a] > 32767 || prod[a] < -32768;
            sat[a]  = prod[a] > 32767 ? 16'sh7fff : prod[a] < -32768 ? 16'sh8000 : prod[a][15:0];
`ifdef DEADBAND_EN
            db[a]   = (sat_q[a] > DB_LO && sat_q[a] < DB_HI) ? '0 : sat_q[a];
`else
            db[a]   = sat_q[a];
`endif
        end
    end

    // At the minimum SAMPLE_DIV the next tick coincides with OUT, so OUT may launch the next sample directly.
    always_comb begin
        nxt = st;
        case (st)
            PRIME:   nxt = tick ? IDLE : PRIME;
            IDLE:    nxt = tick ? DIFF : IDLE;
            DIFF:    nxt = ACCUM;
            ACCUM:   nxt = SCALE;
            SCALE:   nxt = OUT;
            OUT:     nxt = tick ? DIFF : IDLE;
            default: nxt = PRIME;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st    <= PRIME;
            cnt   <= '0;
            wptr  <= '0;
            VALID <= 1'b0;
            OVF   <= 1'b0;
            for (int a = 0; a < 3; a++) begin
                cur[a]   <= '0;
                prev[a]  <= '0;
                delta[a] <= '0;
                sum[a]   <= '0;
                sat_q[a] <= '0;
                rate[a]  <= '0;
                for (int d = 0; d < DEPTH; d++) win[a][d] <= '0;
            end
        end else begin
            st    <= nxt;
            VALID <= st == OUT;
            if (EN) cnt <= tick ? '0 : cnt + 16'd1;
            if (st == ACCUM) wptr <= wptr + AVG_LOG2'(1);
            if (st == SCALE && |clip) OVF <= 1'b1;
            for (int a = 0; a < 3; a++) begin
                if (st == PRIME && tick) prev[a] <= smp[a];
                if ((st == IDLE || st == OUT) && tick) cur[a] <= smp[a];
                if (st == DIFF) begin
                    delta[a] <= 17'(cur[a]) - 17'(prev[a]);
                    prev[a]  <= cur[a];
                end
                if (st == ACCUM) begin
                    sum[a]       <= sum[a] + SW'(delta[a]) - SW'(win[a][wptr]);
                    win[a][wptr] <= delta[a];
                end
                if (st == SCALE) sat_q[a] <= sat[a];
                if (st == OUT) rate[a] <= db[a];
            end
        end
    end

    always @(posedge CLK) begin
        if (RST) begin
            assert (!tick || st == PRIME || st == IDLE || st == OUT) else $error("tick while pipeline busy");
            assert (DB_LO < DB_HI) else $error("deadband bounds inverted");
        end
    end

    assign RX = rate[0];
    assign RY = rate[1];
    assign RZ = rate[2];
endmodule
